// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed seven-segment scanner.
//   NUM_DIGITS - number of scanned digits
//   HEX_SEG    - active-low {g,f,e,d,c,b,a} pattern for each hex nibble
//   SEG_BLANK  - all segments off (active-low)
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the pattern for nibble value n; the list below runs F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: bundle between the LED-capture stage and the display scanner.
//   data_in  - 32-bit display word, nibble i shown on digit i
//   run      - CPU run indicator (0 = halted)
//   blank_lz - blank leading zero digits
//   an       - digit enables, active-low
//   seg      - segments {g,f,e,d,c,b,a}, active-low
//   dp       - decimal point, active-low
// master drives the display word and reads the pins; slave is the scanner.
interface seg7_scan_if;
    logic [31:0] data_in;
    logic        run;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (output data_in, run, blank_lz, input an, seg, dp);
    modport slave  (input data_in, run, blank_lz, output an, seg, dp);
endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low seven-segment decode.
//   nib - 4-bit hex value
//   seg - {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: eight-digit time-multiplexed driver for a common-anode display.
//   clk - system clock
//   rst - asynchronous, active-high reset
//   bus - seg7_scan_if.slave (data_in/run/blank_lz in, an/seg/dp out)
// Each digit is lit for SCAN_DIV cycles. The display word and run flag are
// captured only as the scan wraps back to digit 0, so a frame never shows a
// mix of old and new nibbles.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 32'd100000
)
(
    input  logic       clk,
    input  logic       rst,
    seg7_scan_if.slave bus
);

    // SCAN_DIV of 1 still needs a one-bit counter; it just never leaves 0.
    localparam int unsigned CNT_W = (SCAN_DIV > 32'd1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 32'd1);

    logic [CNT_W-1:0]      div_cnt_r;
    logic [2:0]            idx_r;
    logic [31:0]           shadow_r;
    logic                  run_r;

    logic                  tick_s;
    logic [3:0]            nib_s;
    logic [6:0]            dec_s;
    logic [NUM_DIGITS-1:0] zero_above_s;
    logic                  blank_s;
    logic [7:0]            an_s;
    logic [6:0]            seg_s;
    logic                  dp_s;

    assign tick_s = (div_cnt_r == CNT_LAST);
    assign nib_s  = shadow_r[{idx_r, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nib (nib_s),
        .seg (dec_s)
    );

    // Prescaler, digit index and frame-boundary capture of the display word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
            idx_r     <= 3'd0;
            shadow_r  <= 32'h0000_0000;
            run_r     <= 1'b1;
        end else if (tick_s) begin
            div_cnt_r <= '0;
            idx_r     <= idx_r + 3'd1;
            if (idx_r == 3'd7) begin
                shadow_r <= bus.data_in;
                run_r    <= bus.run;
            end else begin
                shadow_r <= shadow_r;
                run_r    <= run_r;
            end
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    // Per-digit flag: this nibble and every more-significant nibble are zero.
    always_comb begin
        zero_above_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_above_s[i] = ((shadow_r >> (4 * i)) == 32'h0000_0000);
        end
    end

    // Next output values for the digit currently selected by idx_r.
    always_comb begin
        blank_s = 1'b0;
        seg_s   = dec_s;
        dp_s    = 1'b1;
        an_s    = ~(8'h01 << idx_r);
        if (bus.blank_lz && (idx_r != 3'd0) && zero_above_s[idx_r]) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
        if (blank_s) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = dec_s;
        end
        // Decimal point on digit 0 marks a halted CPU.
        if ((idx_r == 3'd0) && !run_r) begin
            dp_s = 1'b0;
        end else begin
            dp_s = 1'b1;
        end
    end

    // Output pin registers; dark while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.an  <= 8'hFF;
            bus.seg <= SEG_BLANK;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= an_s;
            bus.seg <= seg_s;
            bus.dp  <= dp_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed self-checking bench for seg7_scan with SCAN_DIV=4.
module tb_seg7_scan;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    seg7_scan_if bus ();

    seg7_scan #(.SCAN_DIV(32'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until digit d is being driven; an expired budget is a failure.
    task automatic wait_digit(input int d);
        logic [7:0] target;
        target = ~(8'h01 << d);
        for (int k = 0; k < 64; k++) begin
            if (bus.an === target) return;
            step();
        end
        check_eq("wait_digit_timeout", {24'h0, bus.an}, {24'h0, target});
    endtask

    // Land on digit 0 of a frame whose capture happened after this call.
    task automatic sync_frame();
        wait_digit(6);
        wait_digit(7);
        wait_digit(0);
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        rst          = 1'b1;
        bus.data_in  = 32'h0000_0000;
        bus.run      = 1'b1;
        bus.blank_lz = 1'b0;

        // Reset state and first digit timing.
        step();
        step();
        check_eq("rst_an",  {24'h0, bus.an},  32'h0000_00FF);
        check_eq("rst_seg", {25'h0, bus.seg}, 32'h0000_007F);
        check_eq("rst_dp",  {31'h0, bus.dp},  32'h0000_0001);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_eq("first_seg", {25'h0, bus.seg}, 32'h0000_0040);
        check_eq("first_dp",  {31'h0, bus.dp},  32'h0000_0001);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            check_eq("hold_d0_an", {24'h0, bus.an}, 32'h0000_00FE);
        end
        step();
        check_eq("adv_d1_an", {24'h0, bus.an}, 32'h0000_00FD);

        // Plain hex decode.
        bus.data_in = 32'h1234_ABCD;
        sync_frame();
        check_eq("hex_d0_seg", {25'h0, bus.seg}, 32'h0000_0021);
        check_eq("hex_d0_dp",  {31'h0, bus.dp},  32'h0000_0001);
        wait_digit(1);
        check_eq("hex_d1_seg", {25'h0, bus.seg}, 32'h0000_0046);
        wait_digit(4);
        check_eq("hex_d4_seg", {25'h0, bus.seg}, 32'h0000_0019);
        wait_digit(7);
        check_eq("hex_d7_seg", {25'h0, bus.seg}, 32'h0000_0079);
        check_eq("hex_d7_dp",  {31'h0, bus.dp},  32'h0000_0001);

        // Leading-zero blanking.
        bus.data_in  = 32'h0000_00F0;
        bus.blank_lz = 1'b1;
        sync_frame();
        check_eq("lz_d0_seg", {25'h0, bus.seg}, 32'h0000_0040);
        wait_digit(1);
        check_eq("lz_d1_seg", {25'h0, bus.seg}, 32'h0000_000E);
        for (int d = 2; d < 8; d++) begin
            wait_digit(d);
            check_eq("lz_blank_seg", {25'h0, bus.seg}, 32'h0000_007F);
        end

        // Halt marker on digit 0 only, frozen until the next frame.
        bus.data_in  = 32'h0000_0000;
        bus.blank_lz = 1'b0;
        bus.run      = 1'b0;
        sync_frame();
        check_eq("halt_d0_dp", {31'h0, bus.dp}, 32'h0000_0000);
        for (int d = 1; d < 8; d++) begin
            wait_digit(d);
            check_eq("halt_dn_dp", {31'h0, bus.dp}, 32'h0000_0001);
        end
        wait_digit(0);
        check_eq("halt_wrap_dp", {31'h0, bus.dp}, 32'h0000_0000);
        bus.run = 1'b1;
        step();
        check_eq("halt_hold_an", {24'h0, bus.an}, 32'h0000_00FE);
        check_eq("halt_hold_dp", {31'h0, bus.dp}, 32'h0000_0000);
        sync_frame();
        check_eq("run_d0_dp", {31'h0, bus.dp}, 32'h0000_0001);

        // Mid-frame change is not shown until the wrap.
        bus.data_in = 32'h1111_1111;
        sync_frame();
        wait_digit(3);
        bus.data_in = 32'h2222_2222;
        for (int d = 3; d < 8; d++) begin
            wait_digit(d);
            check_eq("torn_old_seg", {25'h0, bus.seg}, 32'h0000_0079);
        end
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            check_eq("torn_new_seg", {25'h0, bus.seg}, 32'h0000_0024);
        end

        // Asynchronous reset mid-frame.
        wait_digit(5);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_an",  {24'h0, bus.an},  32'h0000_00FF);
        check_eq("mid_rst_seg", {25'h0, bus.seg}, 32'h0000_007F);
        check_eq("mid_rst_dp",  {31'h0, bus.dp},  32'h0000_0001);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_eq("restart_an",  {24'h0, bus.an},  32'h0000_00FE);
        check_eq("restart_seg", {25'h0, bus.seg}, 32'h0000_0040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Eight-digit multiplexed seven-segment driver sitting directly downstream of the syscall/LED-capture stage. Takes the 32-bit display word and the run/halt indicator, and scans them as eight hex digits onto the board's common-anode display. A time-multiplexed scan keeps one digit lit at a time. The display word is re-sampled only at frame boundaries so a digit scan never shows a torn value.

## Interface
- SCAN_DIV, 100000: clk cycles each digit stays lit; legal range ≥1.
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- data_in  in  32  display word; nibble i drives digit i (digit 0 = rightmost)
- run  in  1  CPU run indicator (1 = running, 0 = halted waiting for go)
- blank_lz  in  1  1 = blank leading zero digits (digit 0 never blanked)
- an  out  8  digit enables, active-low, one-hot-low when driving
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation
- Prescaler `div_cnt` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when div_cnt == SCAN_DIV-1.
- Digit index `idx` (3 bits) advances on tick, 7→0 wrap.
- Shadow register `shadow` (32 bits) loads `data_in` on a tick where idx==7, i.e. as idx enters 0. No other load path. `run` is sampled into `run_s` at the same instant.
- Digit nibble: `nib = shadow[4*idx +: 4]`, hex-decoded, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Leading-zero blank: digit idx is blank when blank_lz=1, idx≠0, and shadow nibbles idx..7 are all zero.
  - Blank digit: an bit stays asserted, seg = 1111111.
- dp = 0 only when idx==0 and run_s==0 (halt marker); otherwise 1.
- an = ~(8'b1 << idx).

## Timing
- All of an/seg/dp are registered, one cycle behind idx/shadow.
- Reset values:
  - div_cnt=0, idx=0, shadow=0, run_s=1.
  - Outputs: an=8'hFF, seg=7'h7F, dp=1 (display dark).
- First driven output is at the first clk edge after rst deasserts: an=8'hFE, seg=1000000, dp=1.
- Each digit is held exactly SCAN_DIV cycles; a frame is 8·SCAN_DIV cycles.
- data_in latency to display: up to 8·SCAN_DIV+1 cycles. Changes mid-frame are ignored until the next frame boundary.
- SCAN_DIV=1: tick every cycle; idx advances each cycle; a frame is 8 cycles.
- blank_lz is combinational into the output register and takes effect on the next output update, not the next frame.
- rst mid-frame: all state returns to reset values immediately (asynchronous). Scanning resumes from digit 0 with shadow=0.
- data_in changing on the same edge as the frame-boundary load: the value present at that edge is captured.

## Structure
- Package seg7_pkg:
  - NUM_DIGITS=8.
  - 16-entry active-low hex segment constant table.
  - Blank pattern constant 7'h7F.
- Sub-module hex_to_seg7: 4-bit in, 7-bit active-low out, purely combinational, table from seg7_pkg.
- Top holds the prescaler, idx, shadow/run_s, leading-zero logic and output registers.

## Test plan
Directed tests run with SCAN_DIV=4.
- Reset then release, data_in=32'h0:
  - an=FF/seg=7F/dp=1 while rst is high.
  - After release, an=FE, seg=1000000, held 4 cycles, then an=FD.
- data_in=32'h1234ABCD, run=1, blank_lz=0, after one frame boundary:
  - digit0 seg=0100001 (d), digit1 0000110?—correction: digit1 = C = 1000110.
  - digit4 = 4 = 0011001, digit7 = 1 = 1111001.
  - dp=1 throughout.
- data_in=32'h0000_00F0, blank_lz=1:
  - Digits 2..7 show seg=7F with an bit low.
  - digit1 = F = 0001110, digit0 = 0 = 1000000.
- run=0: dp=0 only while an=FE; dp=1 on digits 1..7.
  - Setting run=1 mid-frame leaves dp unchanged until the next frame.
- data_in changed from 32'h11111111 to 32'h22222222 while idx=3:
  - Digits 3..7 still show 1.
  - After the wrap to digit 0, all digits show 2.
- rst pulsed while idx=5:
  - Outputs dark immediately.
  - After release, scan restarts at an=FE with shadow=0.
